// File: rtl/parallel_io_pkg.sv
// Constants shared by the memory-mapped parallel input and output ports.
package parallel_io_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;
  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam logic [WIDTH_DEFAULT-1:0] PORT_ADDR = 8'hFF;
  localparam int unsigned PTR_W = $clog2(DEPTH_DEFAULT);

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/parallel_out_sync_fifo.sv
// Synchronous FIFO with naturally wrapping pointers and a one-bit-wider count.
module sync_fifo
  import parallel_io_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              wr_data,
  output logic [WIDTH-1:0]              rd_data,
  output logic [ptr_width(DEPTH):0]     count,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned PTR_BITS = ptr_width(DEPTH);
  localparam int unsigned CNT_BITS = PTR_BITS + 1;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      // When full with a simultaneous pop, wr_ptr equals rd_ptr: the freed slot is reused.
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CNT_BITS'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/parallel_out.sv
// Memory-mapped parallel output port: stores to PORT_ADDR queue data for a
// valid/ready consumer; stores arriving while full are dropped and flagged.
module parallel_out
  import parallel_io_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [WIDTH-1:0]  PORT_ADDR = parallel_io_pkg::PORT_ADDR
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              Address,
  input  logic [WIDTH-1:0]              WriteData,
  input  logic                          MemWrite,
  output logic [WIDTH-1:0]              Data_out,
  output logic                          Data_valid,
  input  logic                          Data_ready,
  output logic                          Full,
  output logic [$clog2(DEPTH):0]        Count,
  output logic                          Overflow
);

  logic             addr_hit;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] head;
  logic             overflow_q, overflow_d;

  always_comb begin
    addr_hit   = MemWrite && (Address == PORT_ADDR);
    pop        = !fifo_empty && Data_ready;
    push       = addr_hit && (!fifo_full || pop);
    overflow_d = overflow_q || (addr_hit && fifo_full && !pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (WriteData),
    .rd_data (head),
    .count   (Count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign Data_valid = !fifo_empty;
  // Storage is never reset, so mask the head to keep the output defined when empty.
  assign Data_out   = fifo_empty ? '0 : head;
  assign Full       = fifo_full;
  assign Overflow   = overflow_q;

endmodule

// File: tb/tb_parallel_out.sv
// Scoreboard bench for parallel_out: stimulus queues expected drain data,
// a negedge monitor compares every accepted transfer.
module tb_parallel_out;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] Address = '0;
  logic [7:0] WriteData = '0;
  logic       MemWrite = 1'b0;
  logic [7:0] Data_out;
  logic       Data_valid;
  logic       Data_ready = 1'b0;
  logic       Full;
  logic [2:0] Count;
  logic       Overflow;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  parallel_out #(
    .WIDTH     (8),
    .DEPTH     (4),
    .PORT_ADDR (8'hFF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Address    (Address),
    .WriteData  (WriteData),
    .MemWrite   (MemWrite),
    .Data_out   (Data_out),
    .Data_valid (Data_valid),
    .Data_ready (Data_ready),
    .Full       (Full),
    .Count      (Count),
    .Overflow   (Overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [7:0] addr, input logic [7:0] data);
    Address   = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    if (addr == 8'hFF) exp_q.push_back(data);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    Data_ready = 1'b1;
    while (Data_valid && n < 20) begin
      step();
      n++;
    end
    Data_ready = 1'b0;
    chk({name, "_drained"}, {31'd0, Data_valid}, 32'd0);
    chk({name, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  // Monitor: every accepted beat must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && Data_valid && Data_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got %0h expected none", Data_out);
      end else begin
        chk("drain_data", {24'd0, Data_out}, {24'd0, exp_q.pop_front()});
      end
    end else if (rst_n && !Data_valid) begin
      chk("idle_zero", {24'd0, Data_out}, 32'd0);
    end
  end

  initial begin
    // Reset with two queued entries, asserted mid-cycle
    #12;
    rst_n = 1'b1;
    step();
    store(8'hFF, 8'h11);
    step();
    store(8'hFF, 8'h22);
    step();
    MemWrite = 1'b0;
    chk("pre_reset_count", {29'd0, Count}, 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_count", {29'd0, Count}, 32'd0);
    chk("rst_valid", {31'd0, Data_valid}, 32'd0);
    chk("rst_data", {24'd0, Data_out}, 32'd0);
    chk("rst_overflow", {31'd0, Overflow}, 32'd0);
    chk("rst_full", {31'd0, Full}, 32'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();

    // Single store, held for 5 idle cycles
    store(8'hFF, 8'hAA);
    step();
    MemWrite = 1'b0;
    chk("single_valid", {31'd0, Data_valid}, 32'd1);
    chk("single_data", {24'd0, Data_out}, 32'hAA);
    chk("single_count", {29'd0, Count}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("single_hold", {24'd0, Data_out}, 32'hAA);
    end
    drain("single");

    // Non-port store
    store(8'h7F, 8'h55);
    step();
    MemWrite = 1'b0;
    chk("nonport_count", {29'd0, Count}, 32'd0);
    chk("nonport_valid", {31'd0, Data_valid}, 32'd0);

    // Fill, overflow, ordering
    for (int i = 1; i <= 5; i++) begin
      Address   = 8'hFF;
      WriteData = 8'(i);
      MemWrite  = 1'b1;
      if (i <= 4) exp_q.push_back(8'(i));
      step();
      if (i == 4) begin
        chk("fill_full", {31'd0, Full}, 32'd1);
        chk("fill_count", {29'd0, Count}, 32'd4);
        chk("fill_no_ovf", {31'd0, Overflow}, 32'd0);
      end
    end
    MemWrite = 1'b0;
    chk("ovf_set", {31'd0, Overflow}, 32'd1);
    chk("ovf_count", {29'd0, Count}, 32'd4);
    drain("fill");
    chk("ovf_sticky", {31'd0, Overflow}, 32'd1);

    // Simultaneous push and pop while full
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      store(8'hFF, 8'(i));
      step();
    end
    chk("pp_full", {31'd0, Full}, 32'd1);
    store(8'hFF, 8'h10);
    Data_ready = 1'b1;
    step();
    MemWrite   = 1'b0;
    Data_ready = 1'b0;
    chk("pp_count", {29'd0, Count}, 32'd4);
    chk("pp_overflow", {31'd0, Overflow}, 32'd0);
    chk("pp_head", {24'd0, Data_out}, 32'h02);
    drain("pp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parallel_out.md
# parallel_out

Memory-mapped parallel output port for the RV32I single-cycle core, the store-side counterpart of the parallel input port. A store to the port address pushes the write data into a small FIFO. The FIFO drains to an external device over a valid/ready handshake, so the core never stalls on a slow consumer. It sits beside data memory on the Address/WriteData/MemWrite bus.

## Interface
- WIDTH, 8, data and address width in bits.
- DEPTH, 4, FIFO entries; must be a power of two, ≥ 2.
- PORT_ADDR, 8'hFF, address that selects the port; the same value the input port decodes.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- Address  in  WIDTH  core data address.
- WriteData  in  WIDTH  core store data.
- MemWrite  in  1  core store strobe.
- Data_out  out  WIDTH  FIFO head toward the external device.
- Data_valid  out  1  Data_out holds an unread entry.
- Data_ready  in  1  external device accepts Data_out this cycle.
- Full  out  1  FIFO holds DEPTH entries.
- Count  out  $clog2(DEPTH)+1  current number of entries.
- Overflow  out  1  sticky: a store was dropped.

## Operation
- push = MemWrite && (Address == PORT_ADDR) && (!Full || pop).
- pop = Data_valid && Data_ready.
- A store to PORT_ADDR while Full and !pop is dropped and sets Overflow.
  - Overflow stays set until reset.
  - FIFO contents, pointers and Count are unchanged.
- Stores to any other address are ignored. Data memory still handles them; this block does not gate MemWrite.
- Data_out = mem[rd_ptr] when Data_valid, else all zeros (never X).
- Data_valid = (Count != 0).
- Full = (Count == DEPTH).
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Count is one bit wider so it can represent DEPTH.
- Count next value:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Push while empty: the entry becomes the head after the edge. There is no bypass.
- Push and pop together while full: both take effect. The head advances and the new entry is written to the slot just freed.
- Handshake rule: while Data_valid && !Data_ready, Data_out and Data_valid hold stable.
- Data_ready while !Data_valid has no effect.

## Timing
- Reset (rst_n low, asynchronous) clears:
  - rd_ptr = wr_ptr = 0, Count = 0, Overflow = 0.
  - Therefore Data_valid = 0, Full = 0, Data_out = 0.
  - FIFO storage need not be cleared.
- Reset asserted mid-transfer discards all pending entries immediately; outputs return to the values above without waiting for a clock.
- Store-to-visible latency is 1 cycle. A push at edge t gives Data_valid = 1 and Data_out = WriteData from just after t, assuming the FIFO was empty.
- A pop at edge t presents the next entry, or Data_valid = 0, just after t.
- Sustained throughput: one push and one pop per cycle.
- Full, Count and Overflow are registered or decoded from registers only. There is no combinational path from MemWrite or Data_ready to them.
- Data_valid does not depend on Data_ready, so there is no combinational loop.

## Structure
- Shared package parallel_io_pkg holds:
  - PORT_ADDR default, for both the input and output ports.
  - Helper constant PTR_W = $clog2(DEPTH).
- One sub-module: sync_fifo, parameterised by WIDTH and DEPTH.
  - Provides push/pop, head data, count, and full/empty.
  - parallel_out adds the address decode, push gating, Overflow flag and zero-masking of Data_out.

## Test plan
- Reset:
  - Stimulus: assert rst_n = 0 asynchronously mid-cycle with 2 entries queued.
  - Response: Count = 0, Data_valid = 0, Data_out = 8'h00, Overflow = 0 immediately.
- Single store:
  - Stimulus: Address = 8'hFF, WriteData = 8'hAA, MemWrite = 1 for one cycle, Data_ready = 0.
  - Response: next cycle Data_valid = 1, Data_out = 8'hAA, Count = 1. Data_out holds for 5 idle cycles.
- Non-port store:
  - Stimulus: Address = 8'h7F, WriteData = 8'h55, MemWrite = 1.
  - Response: Count stays 0, Data_valid = 0.
- Fill, overflow and ordering:
  - Stimulus: store 8'h01..8'h05 on consecutive cycles, Data_ready = 0.
  - Response after 4 stores: Full = 1, Count = 4. After the fifth: Overflow = 1, Count = 4.
  - Then: raise Data_ready. Data_out reads 01, 02, 03, 04 on successive cycles, then Data_valid = 0.
- Simultaneous push and pop:
  - Stimulus: while full (01..04) and Data_ready = 1, store 8'h10.
  - Response: Count stays 4, Overflow unchanged. Drain order is 02, 03, 04, 10, showing pointer wrap-around.
